motor_agendador: RTL and testbench
==================================

// Module: motor_agendador
// PURPOSE
//  Shares the 28BYJ-48 stepper (ULN2003 inputs IN1..IN4) between two move requesters:
//  req0 = automatic (object-count controller), req1 = manual/maintenance. Arbitrates
//  round-robin, executes one move (N half-steps, direction) at a fixed step rate, holds
//  the coils briefly, then de-energizes and reports completion. Sits between the control
//  FSMs and the coil pins.
// PARAMETERS
//  CLK_FREQ_HZ  25_000_000  system clock frequency
//  STEP_HZ      1000        half-steps per second; STEP_CYC = CLK_FREQ_HZ/STEP_HZ (>=2)
//  HOLD_CYC     250_000     cycles coils stay energized after last step (>=1)
//  STEP_W       16          width of step-count fields
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous reset, active-high
//  req0_valid   in   1       requester 0 has a move pending
//  req0_passos  in   STEP_W  requester 0 half-step count
//  req0_dir     in   1       requester 0 direction (1 = index up, 0 = index down)
//  req0_ready   out  1       requester 0 move accepted this cycle when valid&ready
//  req1_valid / req1_passos / req1_dir / req1_ready   same, requester 1
//  abort        in   1       stop current move immediately
//  bobinas      out  4       coil pattern {IN1,IN2,IN3,IN4}
//  ocupado      out  1       high in RUN and HOLD
//  dono         out  1       requester owning the current/last move
//  done         out  1       one-cycle pulse: move finished or aborted
//  abortado     out  1       one-cycle pulse coincident with done when ended by abort
// BEHAVIOUR
//  - Single clock; rst asynchronous, active-high. Reset: state IDLE, bobinas=0000,
//    ocupado=0, dono=0, done=0, abortado=0, idx=0, prio=0, all counters 0.
//  - Half-step table idx0..7: 1000,1100,0100,0110,0010,0011,0001,1001.
//  - States: IDLE, RUN, HOLD.
//  - IDLE: bobinas=0000. readyX combinational, only in IDLE: if both valid, the one
//    equal to prio wins; if one valid, it wins; the loser's ready=0. Never both ready.
//  - Accept (valid&ready): dono<=winner, prio<=~winner, restante<=passos, timer<=0,
//    RUN next cycle. passos==0: no RUN/HOLD; done=1 next cycle, bobinas stay 0000.
//  - RUN: bobinas=table[idx]. timer counts 0..STEP_CYC-1; at STEP_CYC-1: timer<=0,
//    idx<=idx+1 (dir=1) or idx-1 (dir=0), mod 8 wrap, restante<=restante-1; if
//    restante==1 go HOLD. Exactly passos index advances per move.
//  - HOLD: bobinas=table[idx]; counter 0..HOLD_CYC-1; at HOLD_CYC-1 go IDLE.
//  - done registered: high exactly one cycle, the first IDLE cycle after a move.
//    A new request may be accepted in that same cycle.
//  - idx is NOT cleared between moves (rotor position continuity); only rst clears it.
//  - abort in RUN or HOLD: next cycle IDLE, bobinas=0000, done=1, abortado=1, idx
//    keeps last value. abort in IDLE ignored; abort has priority over a same-cycle step.
//  - req inputs sampled only at accept; changes during RUN/HOLD have no effect.
//  - rst mid-move: outputs return to reset values immediately (asynchronous).
// TESTING (CLK_FREQ_HZ=1000, STEP_HZ=250 -> STEP_CYC=4, HOLD_CYC=3)
//  - req0 passos=3 dir=1 accepted cycle T -> bobinas 1000 T+1..T+4, 1100 T+5..T+8,
//    0100 T+9..T+12, 0110 T+13..T+15, 0000 + done=1 at T+16, dono=0.
//  - Then req1 passos=2 dir=0 -> 0110,0100 (4 cyc each), 1100 held 3 cyc, done.
//  - req0 & req1 valid together three times -> grants 0,1,0; loser ready=0 each time.
//  - passos=0 from req1 -> done one cycle after accept, bobinas 0000 throughout.
//  - idx=7 dir=1 passos=2 -> 1001 then 1000 then 1100 (wrap 7->0).
//  - abort 2 cycles into RUN -> next cycle IDLE, done=abortado=1, bobinas 0000;
//    rst during HOLD -> bobinas 0000, ocupado=0 immediately, next move starts at 1000.

Source files
------------

// File: rtl/motor_agendador.sv
// motor_agendador: shares one 28BYJ-48 stepper between an automatic requester (0)
// and a manual/maintenance requester (1). Grants moves round-robin, steps the
// half-step table at a fixed rate, holds the coils briefly, then releases them.
module motor_agendador #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int STEP_HZ     = 1000,
  parameter int HOLD_CYC    = 250_000,
  parameter int STEP_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [STEP_W-1:0] req0_passos,
  input  logic              req0_dir,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [STEP_W-1:0] req1_passos,
  input  logic              req1_dir,
  output logic              req1_ready,
  input  logic              abort,
  output logic [3:0]        bobinas,
  output logic              ocupado,
  output logic              dono,
  output logic              done,
  output logic              abortado
);

  localparam int STEP_CYC = CLK_FREQ_HZ / STEP_HZ;
  // One shared counter serves both the step timer and the hold timer
  localparam int CNT_MAX  = (STEP_CYC > HOLD_CYC) ? STEP_CYC : HOLD_CYC;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t            state;
  logic [2:0]        idx;
  logic              prio;
  logic              dir_q;
  logic [STEP_W-1:0] restante;
  logic [CNT_W-1:0]  cnt;

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              winner;
  logic [STEP_W-1:0] acc_passos;
  logic              acc_dir;
  logic [2:0]        idx_next;

  // Half-step coil pattern {IN1,IN2,IN3,IN4} for a rotor index
  function automatic logic [3:0] fase(input logic [2:0] i);
    logic [3:0] f;
    case (i)
      3'd0:    f = 4'b1000;
      3'd1:    f = 4'b1100;
      3'd2:    f = 4'b0100;
      3'd3:    f = 4'b0110;
      3'd4:    f = 4'b0010;
      3'd5:    f = 4'b0011;
      3'd6:    f = 4'b0001;
      default: f = 4'b1001;
    endcase
    return f;
  endfunction

  // Round-robin grant, offered only while idle; prio breaks ties
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~prio;
        grant1 = prio;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign winner     = grant1;
  assign acc_passos = winner ? req1_passos : req0_passos;
  assign acc_dir    = winner ? req1_dir : req0_dir;
  // 3-bit arithmetic gives the mod-8 wrap for free
  assign idx_next   = dir_q ? (idx + 3'd1) : (idx - 3'd1);

  // Scheduler FSM: accept, step the table, hold, release; all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 3'd0;
      prio     <= 1'b0;
      dir_q    <= 1'b0;
      restante <= '0;
      cnt      <= '0;
      bobinas  <= 4'b0000;
      ocupado  <= 1'b0;
      dono     <= 1'b0;
      done     <= 1'b0;
      abortado <= 1'b0;
    end else begin
      done     <= 1'b0;
      abortado <= 1'b0;
      case (state)
        IDLE: begin
          bobinas <= 4'b0000;
          ocupado <= 1'b0;
          if (accept) begin
            dono     <= winner;
            prio     <= ~winner;
            restante <= acc_passos;
            dir_q    <= acc_dir;
            cnt      <= '0;
            if (acc_passos == '0) begin
              done <= 1'b1;
            end else begin
              state   <= RUN;
              bobinas <= fase(idx);
              ocupado <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state    <= IDLE;
            bobinas  <= 4'b0000;
            ocupado  <= 1'b0;
            cnt      <= '0;
            done     <= 1'b1;
            abortado <= 1'b1;
          end else if (cnt == STEP_LAST) begin
            cnt      <= '0;
            idx      <= idx_next;
            restante <= restante - 1'b1;
            bobinas  <= fase(idx_next);
            if (restante == STEP_W'(1)) begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (abort) begin
            state    <= IDLE;
            bobinas  <= 4'b0000;
            ocupado  <= 1'b0;
            cnt      <= '0;
            done     <= 1'b1;
            abortado <= 1'b1;
          end else if (cnt == HOLD_LAST) begin
            state   <= IDLE;
            bobinas <= 4'b0000;
            ocupado <= 1'b0;
            cnt     <= '0;
            done    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          bobinas <= 4'b0000;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_agendador.sv
// tb_motor_agendador: drives directed and random moves into motor_agendador and
// compares every cycle against a position/priority model of the scheduler.
module tb_motor_agendador;

  localparam int STEP_W = 16;
  localparam int SC     = 4;
  localparam int HC     = 3;

  logic              clk;
  logic              rst;
  logic              req0_valid;
  logic [STEP_W-1:0] req0_passos;
  logic              req0_dir;
  logic              req0_ready;
  logic              req1_valid;
  logic [STEP_W-1:0] req1_passos;
  logic              req1_dir;
  logic              req1_ready;
  logic              abort;
  logic [3:0]        bobinas;
  logic              ocupado;
  logic              dono;
  logic              done;
  logic              abortado;

  int assertCount  = 0;
  int failureCount = 0;

  // Reference model: rotor index and next-priority requester
  int idx_m  = 0;
  int prio_m = 0;
  logic [3:0] tbl [8];

  motor_agendador #(
    .CLK_FREQ_HZ(1000),
    .STEP_HZ    (250),
    .HOLD_CYC   (HC),
    .STEP_W     (STEP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_passos(req0_passos),
    .req0_dir   (req0_dir),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_passos(req1_passos),
    .req1_dir   (req1_dir),
    .req1_ready (req1_ready),
    .abort      (abort),
    .bobinas    (bobinas),
    .ocupado    (ocupado),
    .dono       (dono),
    .done       (done),
    .abortado   (abortado)
  );

  // Free-running clock, posedges at 5,15,25...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int posAt(input int base, input bit d, input int k);
    return (((base + (d ? k : -k)) % 8) + 8) % 8;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failureCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scrambles request fields so changes during a move are proven harmless
  task automatic applyStimulus(input bit v);
    req0_valid  = v;
    req1_valid  = v;
    req0_passos = 16'($urandom_range(0, 9));
    req1_passos = 16'($urandom_range(0, 9));
    req0_dir    = 1'($urandom_range(0, 1));
    req1_dir    = 1'($urandom_range(0, 1));
  endtask

  // One full move from an IDLE negedge; ends at the done-cycle negedge.
  // abortAt/resetAt: 1-based busy cycle in which abort/rst is raised (0 = never).
  task automatic doMove(input int who, input int n, input bit d, input int abortAt,
                        input bit both, input int resetAt);
    int  w;
    int  busy;
    int  pos;
    bit  ab;
    bit  rs;
    w = both ? prio_m : who;
    req0_valid = both || (who == 0);
    req1_valid = both || (who == 1);
    if (w == 0) begin
      req0_passos = 16'(n);
      req0_dir    = d;
      req1_passos = 16'($urandom_range(1, 5));
      req1_dir    = 1'($urandom_range(0, 1));
    end else begin
      req1_passos = 16'(n);
      req1_dir    = d;
      req0_passos = 16'($urandom_range(1, 5));
      req0_dir    = 1'($urandom_range(0, 1));
    end
    #1;
    checkOutput("ready0_grant", req0_ready, (w == 0));
    checkOutput("ready1_grant", req1_ready, (w == 1));
    prio_m = 1 - w;
    busy = (n == 0) ? 0 : SC * n + HC;
    ab = 0;
    rs = 0;
    for (int j = 0; j < busy && !ab && !rs; j++) begin
      @(negedge clk);
      pos = (j < SC * n) ? posAt(idx_m, d, j / SC) : posAt(idx_m, d, n);
      checkOutput("bobinas_busy", bobinas, tbl[pos]);
      checkOutput("ocupado_busy", ocupado, 1);
      checkOutput("done_busy", done, 0);
      checkOutput("dono_busy", dono, w);
      applyStimulus(1'b1);
      abort = (j + 1 == abortAt);
      #1;
      checkOutput("ready0_busy", req0_ready, 0);
      checkOutput("ready1_busy", req1_ready, 0);
      if (abort) begin
        idx_m = pos;
        ab = 1;
      end
      if (j + 1 == resetAt) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("bobinas_rst", bobinas, 4'b0000);
        checkOutput("ocupado_rst", ocupado, 0);
        checkOutput("dono_rst", dono, 0);
        rst = 1'b0;
        idx_m = 0;
        prio_m = 0;
        rs = 1;
      end
    end
    if (rs) begin
      @(negedge clk);
      checkOutput("done_after_rst", done, 0);
      checkOutput("bobinas_after_rst", bobinas, 4'b0000);
    end else begin
      if (!ab && n > 0) idx_m = posAt(idx_m, d, n);
      @(negedge clk);
      abort = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checkOutput("bobinas_done", bobinas, 4'b0000);
      checkOutput("done_pulse", done, 1);
      checkOutput("abortado_flag", abortado, ab);
      checkOutput("ocupado_done", ocupado, 0);
      checkOutput("dono_done", dono, w);
    end
  endtask

  // A quiet idle cycle; abort may be raised to show it is ignored in IDLE
  task automatic idleCycle(input bit abortVal);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    abort = abortVal;
    #1;
    checkOutput("ready0_idle", req0_ready, 0);
    checkOutput("ready1_idle", req1_ready, 0);
    @(negedge clk);
    abort = 1'b0;
    checkOutput("bobinas_idle", bobinas, 4'b0000);
    checkOutput("done_idle", done, 0);
    checkOutput("abortado_idle", abortado, 0);
    checkOutput("ocupado_idle", ocupado, 0);
  endtask

  // Directed spec scenarios followed by randomized moves
  initial begin
    int who;
    int n;
    bit d;
    bit both;
    int abAt;
    tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    rst = 1'b1;
    abort = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_passos = '0;
    req1_passos = '0;
    req0_dir = 1'b0;
    req1_dir = 1'b0;
    @(negedge clk);
    checkOutput("reset_bobinas", bobinas, 4'b0000);
    checkOutput("reset_ocupado", ocupado, 0);
    checkOutput("reset_dono", dono, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_abortado", abortado, 0);
    @(negedge clk);
    rst = 1'b0;
    idleCycle(1'b0);

    doMove(0, 3, 1'b1, 0, 1'b0, 0);
    doMove(1, 2, 1'b0, 0, 1'b0, 0);
    doMove(0, 1, 1'b1, 0, 1'b1, 0);
    doMove(0, 1, 1'b1, 0, 1'b1, 0);
    doMove(0, 1, 1'b1, 0, 1'b1, 0);
    doMove(1, 0, 1'b1, 0, 1'b0, 0);
    idleCycle(1'b0);

    // Rotor continuity across the 7->0 wrap
    rst = 1'b1;
    idx_m = 0;
    prio_m = 0;
    @(negedge clk);
    rst = 1'b0;
    doMove(0, 1, 1'b0, 0, 1'b0, 0);
    doMove(0, 2, 1'b1, 0, 1'b0, 0);

    // Aborts in RUN, on a step boundary, in HOLD, and abort ignored in IDLE
    doMove(1, 3, 1'b1, 3, 1'b0, 0);
    doMove(0, 2, 1'b0, SC, 1'b0, 0);
    doMove(1, 2, 1'b1, SC * 2 + 2, 1'b0, 0);
    idleCycle(1'b1);

    // Reset during HOLD, next move starts from index 0
    doMove(0, 2, 1'b1, 0, 1'b0, SC * 2 + 2);
    doMove(0, 1, 1'b1, 0, 1'b0, 0);

    for (int k = 0; k < 12; k++) begin
      who  = int'($urandom_range(0, 1));
      n    = int'($urandom_range(0, 4));
      d    = 1'($urandom_range(0, 1));
      both = ($urandom_range(0, 3) == 0);
      abAt = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, SC * n + HC)) : 0;
      doMove(who, n, d, abAt, both, 0);
      if ($urandom_range(0, 1) == 1) idleCycle(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failureCount);
    $finish;
  end

endmodule
